// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing MNIST sequencer.
package sc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WARM,
    ST_RUN,
    ST_ARGMAX,
    ST_DONE
  } sc_state_e;

  // XOR feedback taps for maximal-length Fibonacci LFSRs.
  // Bit n-1 is set for polynomial term x^n. Supported widths are 8..16.
  function automatic logic [15:0] lfsr_taps(input int width);
    case (width)
      8:       lfsr_taps = 16'h00B8;  // x^8 + x^6 + x^5 + x^4 + 1
      9:       lfsr_taps = 16'h0110;  // x^9 + x^5 + 1
      10:      lfsr_taps = 16'h0240;  // x^10 + x^7 + 1
      11:      lfsr_taps = 16'h0500;  // x^11 + x^9 + 1
      12:      lfsr_taps = 16'h0829;  // x^12 + x^6 + x^4 + x + 1
      13:      lfsr_taps = 16'h100D;  // x^13 + x^4 + x^3 + x + 1
      14:      lfsr_taps = 16'h2015;  // x^14 + x^5 + x^3 + x + 1
      15:      lfsr_taps = 16'h6000;  // x^15 + x^14 + 1
      16:      lfsr_taps = 16'hD008;  // x^16 + x^15 + x^13 + x^4 + 1
      default: lfsr_taps = 16'h0000;
    endcase
  endfunction

  // Bits needed to hold the values 0..n inclusive.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to index n items (at least one bit).
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sc_mnist_inference_ctrl_if.sv
// Host-side handshake of the inference sequencer: start request and result.
interface sc_mnist_inference_ctrl_if #(
  parameter int IW = 4,
  parameter int CW = 9
);
  logic          start;
  logic          busy;
  logic          done;
  logic [IW-1:0] class_out;
  logic [CW-1:0] class_count;

  modport master (output start, input busy, done, class_out, class_count);
  modport slave  (input start, output busy, done, class_out, class_count);
endinterface

// File: rtl/sc_lfsr.sv
// Maximal-length Fibonacci LFSR with synchronous reload to its seed.
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int          WIDTH = 11,
  parameter int unsigned SEED  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] TAPS   = WIDTH'(lfsr_taps(WIDTH));

  // The all-zero state is a lock-up state of an XOR LFSR.
  if (SEED_V == '0) begin : g_bad_seed
    $error("sc_lfsr: SEED must be nonzero");
  end
  if (WIDTH < 8 || WIDTH > 16) begin : g_bad_width
    $error("sc_lfsr: WIDTH must be in 8..16");
  end

  logic feedback;
  assign feedback = ^(state & TAPS);

  // Reload on reset/load, otherwise shift in the parity of the tapped bits.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      state <= SEED_V;
    end else if (step) begin
      state <= {state[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/sc_mnist_inference_ctrl.sv
// Sequencer for the two-layer stochastic-computing MNIST network: reseeds the
// select LFSRs, streams the network, counts output 1s and picks the argmax.
module sc_mnist_inference_ctrl
  import sc_pkg::*;
#(
  parameter int N2         = 10,
  parameter int K1         = 10,
  parameter int K2         = 7,
  parameter int STREAM_LEN = 256,
  parameter int PIPE_LAT   = 1,
  parameter int SEED1      = 1,
  parameter int SEED2      = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  sc_mnist_inference_ctrl_if.slave  host,
  input  logic [N2-1:0]             net_dout,
  output logic [K1:0]               sel1,
  output logic [K2:0]               sel2,
  output logic                      stream_en
);

  localparam int CW = count_width(STREAM_LEN);
  localparam int IW = index_width(N2);
  localparam int MAX_SL_N2 = (STREAM_LEN > N2) ? STREAM_LEN : N2;
  localparam int PHASE_MAX = (MAX_SL_N2 > PIPE_LAT) ? MAX_SL_N2 : PIPE_LAT;
  localparam int PW = count_width(PHASE_MAX);

  localparam logic [PW-1:0] WARM_LAST = PW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
  localparam logic [PW-1:0] RUN_LAST  = PW'(STREAM_LEN - 1);
  localparam logic [PW-1:0] ARG_LAST  = PW'(N2 - 1);

  sc_state_e      state_q, state_d;
  logic [PW-1:0]  phase_q;
  logic           lfsr_load;
  logic           busy_c;
  logic           done_c;

  logic [CW-1:0]  cnt_q [N2];
  logic [IW-1:0]  arg_idx, best_idx_q, nxt_idx, class_q;
  logic [CW-1:0]  cand_cnt, best_cnt_q, nxt_cnt, count_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Cycle counter within WARM/RUN/ARGMAX; restarts at every state change.
  always_ff @(posedge clk) begin
    if (reset || state_d != state_q) begin
      phase_q <= '0;
    end else if (state_q == ST_WARM || state_q == ST_RUN || state_q == ST_ARGMAX) begin
      phase_q <= phase_q + PW'(1);
    end else begin
      phase_q <= '0;
    end
  end

  // Next-state and control outputs.
  always_comb begin
    state_d   = state_q;
    stream_en = 1'b0;
    lfsr_load = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (host.start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy_c    = 1'b1;
        lfsr_load = 1'b1;
        state_d   = (PIPE_LAT == 0) ? ST_RUN : ST_WARM;
      end
      ST_WARM: begin
        busy_c    = 1'b1;
        stream_en = 1'b1;
        if (phase_q == WARM_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy_c    = 1'b1;
        stream_en = 1'b1;
        if (phase_q == RUN_LAST) state_d = ST_ARGMAX;
      end
      ST_ARGMAX: begin
        busy_c = 1'b1;
        if (phase_q == ARG_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign host.busy        = busy_c;
  assign host.done        = done_c;
  assign host.class_out   = class_q;
  assign host.class_count = count_q;

  sc_lfsr #(.WIDTH(K1 + 1), .SEED(SEED1)) u_sel1 (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .step  (stream_en),
    .state (sel1)
  );

  sc_lfsr #(.WIDTH(K2 + 1), .SEED(SEED2)) u_sel2 (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .step  (stream_en),
    .state (sel2)
  );

  // Per-class 1s counters: cleared before each inference, accumulate in RUN only.
  always_ff @(posedge clk) begin
    if (reset || state_q == ST_CLEAR) begin
      for (int i = 0; i < N2; i++) cnt_q[i] <= '0;
    end else if (state_q == ST_RUN) begin
      for (int i = 0; i < N2; i++) cnt_q[i] <= cnt_q[i] + CW'(net_dout[i]);
    end
  end

  // One candidate per ARGMAX cycle; strict compare keeps the lowest index on ties.
  always_comb begin
    arg_idx  = phase_q[IW-1:0];
    cand_cnt = cnt_q[arg_idx];
    nxt_idx  = best_idx_q;
    nxt_cnt  = best_cnt_q;
    if (cand_cnt > best_cnt_q) begin
      nxt_idx = arg_idx;
      nxt_cnt = cand_cnt;
    end
  end

  // Running best, cleared together with the counters.
  always_ff @(posedge clk) begin
    if (reset || state_q == ST_CLEAR) begin
      best_idx_q <= '0;
      best_cnt_q <= '0;
    end else if (state_q == ST_ARGMAX) begin
      best_idx_q <= nxt_idx;
      best_cnt_q <= nxt_cnt;
    end
  end

  // Result registers, loaded on the edge that enters DONE and held afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      class_q <= '0;
      count_q <= '0;
    end else if (state_q == ST_ARGMAX && phase_q == ARG_LAST) begin
      class_q <= nxt_idx;
      count_q <= nxt_cnt;
    end
  end

endmodule
